// File: rtl/mult_seq.sv
// Iterative shift-add multiplier with valid/ready on both sides.
// Retires BITS_PER_CYCLE multiplier bits per clock on operand magnitudes.
// The sign is applied once, when the result is written to Product.
module mult_seq #(
    parameter int A_WIDTH        = 12,
    parameter int B_WIDTH        = 12,
    parameter int BITS_PER_CYCLE = 1   // must divide B_WIDTH
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [A_WIDTH-1:0]         Din,
    input  logic [B_WIDTH-1:0]         Coeff,
    input  logic                       Signed_Mode,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [A_WIDTH+B_WIDTH-1:0] Product
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int ITER    = B_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured operand magnitudes and the result sign
    logic [A_WIDTH-1:0]        mag_a_p0;
    logic [B_WIDTH-1:0]        mag_b_p0;
    logic                      sign_p0;

    // Iteration state and result register
    logic [P_WIDTH-1:0]        acc_p1;
    logic [CNT_W-1:0]          cnt_p1;
    logic [P_WIDTH-1:0]        product_p2;

    logic [31:0]               shamt;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [P_WIDTH-1:0]        partial;
    logic [P_WIDTH-1:0]        acc_sum;
    logic                      last_iter;

    // Magnitude of the multiplicand; the most-negative value maps to 2^(N-1),
    // which still fits in the N-bit unsigned result.
    function automatic logic [A_WIDTH-1:0] mag_of_a(input logic [A_WIDTH-1:0] v,
                                                    input logic             sgn);
        logic signed [A_WIDTH-1:0] sv;
        sv = signed'(v);
        return (sgn && v[A_WIDTH-1]) ? unsigned'(-sv) : v;
    endfunction

    // Magnitude of the multiplier, same treatment as the multiplicand.
    function automatic logic [B_WIDTH-1:0] mag_of_b(input logic [B_WIDTH-1:0] v,
                                                    input logic             sgn);
        logic signed [B_WIDTH-1:0] sv;
        sv = signed'(v);
        return (sgn && v[B_WIDTH-1]) ? unsigned'(-sv) : v;
    endfunction

    // Two's-complement negation of the unsigned magnitude product when needed.
    function automatic logic [P_WIDTH-1:0] apply_sign(input logic [P_WIDTH-1:0] m,
                                                      input logic             neg);
        return neg ? (~m + P_WIDTH'(1)) : m;
    endfunction

    assign last_iter = (cnt_p1 == LAST);

    // Partial product for the current multiplier digit, aligned to its weight
    always_comb begin
        shamt   = 32'(cnt_p1) * 32'(BITS_PER_CYCLE);
        digit   = BITS_PER_CYCLE'(mag_b_p0 >> shamt);
        partial = (P_WIDTH'(mag_a_p0) * P_WIDTH'(digit)) << shamt;
        acc_sum = acc_p1 + partial;
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt = state;
        In_Ready  = 1'b0;
        Out_Valid = 1'b0;
        unique case (state)
            IDLE: begin
                In_Ready = 1'b1;
                if (In_Valid) state_nxt = CALC;
            end
            CALC: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                Out_Valid = 1'b1;
                if (Out_Ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and result load
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_p1     <= '0;
            cnt_p1     <= '0;
            sign_p0    <= 1'b0;
            product_p2 <= '0;
        end else begin
            unique case (state)
                // stage 0: capture magnitudes and sign
                IDLE: begin
                    if (In_Valid) begin
                        mag_a_p0 <= mag_of_a(Din, Signed_Mode);
                        mag_b_p0 <= mag_of_b(Coeff, Signed_Mode);
                        sign_p0  <= Signed_Mode & (Din[A_WIDTH-1] ^ Coeff[B_WIDTH-1]);
                        acc_p1   <= '0;
                        cnt_p1   <= '0;
                    end
                end
                // stage 1: accumulate one digit per cycle; stage 2: signed result
                CALC: begin
                    acc_p1 <= acc_sum;
                    cnt_p1 <= cnt_p1 + CNT_W'(1);
                    if (last_iter) begin
                        product_p2 <= apply_sign(acc_sum, sign_p0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Product = product_p2;

endmodule

// File: doc/mult_seq.md
# mult_seq

Iterative signed/unsigned shift-add multiplier with a valid/ready handshake on both sides. It is the parametrised successor to the fixed 12x12 combinational multiplier in the FIR datapath. It trades latency for area by retiring `BITS_PER_CYCLE` multiplier bits per clock. Operand widths, the bits retired per cycle and the signed/unsigned mode are all selectable.

## Interface
Parameters:
- `A_WIDTH`, default 12: width of `Din` (multiplicand).
- `B_WIDTH`, default 12: width of `Coeff` (multiplier).
- `BITS_PER_CYCLE`, default 1: multiplier bits retired per cycle.
  - Must divide `B_WIDTH`.
  - Define `ITER = B_WIDTH / BITS_PER_CYCLE`.

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  — single clock; all state updates on the rising edge.
- `Rst`  in  1  — synchronous, active-high reset.
- `In_Valid`  in  1  — operands present.
- `In_Ready`  out  1  — block can accept operands.
- `Din`  in  `A_WIDTH`  — multiplicand.
- `Coeff`  in  `B_WIDTH`  — multiplier.
- `Signed_Mode`  in  1  — 1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- `Out_Valid`  out  1  — `Product` valid.
- `Out_Ready`  in  1  — downstream accepts `Product`.
- `Product`  out  `A_WIDTH+B_WIDTH`  — full-precision result, registered.

## Operation
States:
- **IDLE**
  - `In_Ready` = 1.
  - On `In_Valid` = 1, capture the operands and go to CALC.
  - Captured in signed mode: `|Din|`, `|Coeff|` (as `A_WIDTH`/`B_WIDTH`-bit unsigned magnitudes) and the sign bit `Din[MSB] ^ Coeff[MSB]`.
  - Captured in unsigned mode: the raw values, with sign = 0.
  - Clear the accumulator and the iteration counter.
- **CALC**
  - `In_Ready` = 0; `In_Valid` is ignored.
  - Each cycle, add `magA * magB[k*BPC +: BPC]`, shifted left by `k*BPC`, into the `A_WIDTH+B_WIDTH` accumulator, where k is the counter.
  - Increment k.
  - After the `ITER`-th add, load `Product` with the accumulator, two's-complement negated if sign = 1, then go to DONE.
- **DONE**
  - `Out_Valid` = 1 and `In_Ready` = 0.
  - `Product` is held stable until `Out_Valid && Out_Ready`; then go to IDLE.

Arithmetic rules:
- A most-negative operand (e.g. -2048 at 12 bits) has magnitude 2^(N-1), which fits in the N-bit unsigned magnitude. No overflow is possible in `A_WIDTH+B_WIDTH` bits for either mode.
- Negating a zero result yields zero.
- A zero operand still takes the full `ITER` cycles; there is no early termination.

Reset:
- While `Rst` = 1 on an edge: state ← IDLE, accumulator, counter and sign ← 0, `Product` ← 0, `Out_Valid` ← 0.
- `In_Ready` is decoded from state, so it reads 1 in the cycle after reset is released.
- A reset mid-CALC or mid-DONE discards the operation; no result is emitted.
- A reset takes priority over a simultaneous handshake on either side.

`Product` retains the last result after it is consumed, until the next completion overwrites it.

## Timing
- Acceptance edge T: `In_Valid && In_Ready` sampled high.
- CALC occupies the cycles between edges T+1 … T+`ITER`.
- `Out_Valid` rises after edge T+`ITER`, so latency from acceptance to `Out_Valid` is `ITER` cycles: 12 with defaults, 3 with `BITS_PER_CYCLE` = 4.
- Output handshake at edge U:
  - The state is IDLE after U.
  - `In_Ready` is 1 in the next cycle.
  - The next accept is at U+1 at the earliest.
- Minimum initiation interval is `ITER`+2 cycles. There is no overlap of operations.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.

## Test plan
- **Signed basic.** Defaults, `Signed_Mode` = 1, `Din` = 5, `Coeff` = 12'hFFD (-3). Required:
  - `Product` = 24'hFFFFF1 (-15).
  - `Out_Valid` exactly 12 cycles after the accept edge.
  - `In_Ready` = 0 throughout.
- **Extremes.** Signed: `Din` = `Coeff` = 12'h800 → 24'h400000. Signed: `Din` = 12'h800, `Coeff` = 12'h7FF → 24'hC00800. Unsigned: 12'hFFF × 12'hFFF → 24'hFFE001. Zero: 0 × 12'h800 (signed) → 0.
- **Backpressure.** Hold `Out_Ready` = 0 for 5 cycles after `Out_Valid` rises. Required:
  - `Product` and `Out_Valid` stay stable.
  - `In_Ready` stays 0 and a pulsed `In_Valid` is not accepted.
  - Releasing `Out_Ready` gives a handshake, then `In_Ready` = 1 on the next cycle.
- **Reset mid-operation.** Assert `Rst` for one cycle at CALC iteration 6. Required:
  - `Out_Valid` = 0 and `Product` = 0 after the edge.
  - `In_Ready` = 1 in the next cycle.
  - A new 7 × 9 operation yields 63 with full latency.
- **Parametrised.** `A_WIDTH` = 16, `B_WIDTH` = 8, `BITS_PER_CYCLE` = 4, signed: 16'h8000 × 8'h80 → 24'h400000 after 2 cycles; 16'h1234 × 8'h03 → 24'h00369C.
- **Back-to-back stream.** Keep `In_Valid` and `Out_Ready` at 1 for 20 random signed pairs. Required:
  - Every product matches the reference model.
  - Initiation interval is exactly 14 cycles with defaults.
